// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter - AHB-2 round-robin bus arbiter.
//   Grants the bus to one master at a time and rotates fairly between requesters.
//   Fixed-length bursts (4/8/16 beats) and locked sequences keep the grant until they end.
//   An ERROR/RETRY/SPLIT response aborts a burst or a lock.
// Ports:
//   hclk, hreset       clock, synchronous active-high reset
//   busreq, hlock      per-master request / locked-access request
//   htrans, hburst     transfer and burst type of the current address-phase owner
//   hready, hresp      shared transfer-done and response from the slave mux
//   hgrant             one-hot grant (registered)
//   hmaster            address-phase owner index (registered)
//   hmastlock          owner is doing a locked transfer (registered)
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] busreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [3:0]             hmaster,
  output logic                   hmastlock
);
  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_LOCKED} state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_hgrant;
  logic [3:0]             r_hmaster;
  logic                   r_hmastlock;
  logic [3:0]             r_beat_cnt;
  logic [3:0]             r_rr_ptr;

  logic [3:0]             w_grant_idx;
  logic [3:0]             w_winner;
  logic [3:0]             w_burst_len;
  logic [NUM_MASTERS-1:0] w_win_oh;
  logic                   w_any_req;
  logic                   w_win_lock;
  logic                   w_own_lock;
  logic                   w_burst_start;
  logic                   w_arb_ok;
  logic                   w_abort;

  assign hgrant    = r_hgrant;
  assign hmaster   = r_hmaster;
  assign hmastlock = r_hmastlock;

  // Index of the one-hot grant holder.
  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (r_hgrant[i]) w_grant_idx = 4'(i);
  end

  // Round-robin scan rr_ptr+1 .. rr_ptr+NUM_MASTERS. Scanning from the far end
  // downwards lets the nearest requester overwrite earlier hits.
  always_comb begin
    int j;
    j         = 0;
    w_winner  = 4'(DEFAULT_MASTER);
    w_any_req = |busreq;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (busreq[j]) w_winner = 4'(j);
    end
  end

  assign w_win_oh   = NUM_MASTERS'(1) << w_winner;
  // Grant is one-hot, so masking avoids indexing with a possibly wider index.
  assign w_own_lock = |(hlock & r_hgrant);
  assign w_win_lock = w_any_req & |(hlock & w_win_oh);

  // hburst encodings 2..7 are the fixed-length bursts (WRAP4..INCR16).
  always_comb begin
    case (hburst)
      3'd2, 3'd3: w_burst_len = 4'd3;
      3'd4, 3'd5: w_burst_len = 4'd7;
      3'd6, 3'd7: w_burst_len = 4'd15;
      default:    w_burst_len = 4'd0;
    endcase
  end

  assign w_burst_start = (htrans == TR_NONSEQ) && (hburst >= 3'd2);
  // First response cycle of a non-OKAY response.
  assign w_abort       = (hresp != 2'b00) && !hready;

  always_comb begin
    w_arb_ok = 1'b0;
    case (r_state)
      ST_ARB:   w_arb_ok = hready && !w_burst_start;
      // Last beat accepted, or the master ended the burst early.
      ST_BURST: w_arb_ok = hready && ((htrans == TR_SEQ && r_beat_cnt == 4'd1) ||
                                      htrans == TR_IDLE || htrans == TR_NONSEQ);
      default:  w_arb_ok = 1'b0;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state     <= ST_ARB;
      r_hgrant    <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      r_hmaster   <= 4'(DEFAULT_MASTER);
      r_hmastlock <= 1'b0;
      r_beat_cnt  <= '0;
      r_rr_ptr    <= 4'(DEFAULT_MASTER);
    end else begin
      if (hready) begin
        r_hmaster   <= w_grant_idx;
        r_hmastlock <= w_own_lock;
      end
      if (w_abort) begin
        r_state    <= ST_ARB;
        r_beat_cnt <= '0;
      end else if (w_arb_ok) begin
        r_hgrant   <= w_win_oh;
        if (w_any_req) r_rr_ptr <= w_winner;
        r_state    <= w_win_lock ? ST_LOCKED : ST_ARB;
        r_beat_cnt <= '0;
      end else begin
        case (r_state)
          ST_ARB:
            if (hready && w_burst_start) begin
              r_state    <= ST_BURST;
              r_beat_cnt <= w_burst_len;
            end
          ST_BURST:
            // BUSY and stalled beats hold the count.
            if (hready && htrans == TR_SEQ) r_beat_cnt <= r_beat_cnt - 4'd1;
          ST_LOCKED:
            // Lock released: keep the grant this edge, rearbitrate on the next.
            if (hready && !w_own_lock) r_state <= ST_ARB;
          default: r_state <= ST_ARB;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Scoreboard bench for ahb_rr_arbiter: each directed vector pushes its
// hand-computed post-edge outputs; a monitor pops and compares after every edge.
module tb_ahb_rr_arbiter;
  localparam int N = 4;
  localparam logic [1:0] IDLE = 2'd0, NS = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SGL = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;

  logic         hclk = 1'b0;
  logic         hreset;
  logic [N-1:0] busreq, hlock;
  logic [1:0]   htrans, hresp;
  logic [2:0]   hburst;
  logic         hready;
  logic [N-1:0] hgrant;
  logic [3:0]   hmaster;
  logic         hmastlock;

  typedef struct {
    string        tag;
    logic [N-1:0] g;
    logic [3:0]   m;
    logic         l;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [3:0] t2_g [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
  logic [3:0] t2_m [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};

  always #5 hclk = ~hclk;

  ahb_rr_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0)) dut (
    .hclk(hclk), .hreset(hreset), .busreq(busreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, expect (eg, em, el) after the next rising edge.
  task automatic cyc(input logic rst, input logic [N-1:0] req, input logic [N-1:0] lk,
                     input logic [1:0] tr, input logic [2:0] hb, input logic rdy,
                     input logic [1:0] rsp, input logic [N-1:0] eg, input logic [3:0] em,
                     input logic el, input string tag);
    exp_t e;
    @(negedge hclk);
    hreset = rst; busreq = req; hlock = lk; htrans = tr; hburst = hb;
    hready = rdy; hresp = rsp;
    e.tag = tag; e.g = eg; e.m = em; e.l = el;
    sb.push_back(e);
    @(posedge hclk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge hclk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, ".hgrant"},    32'(hgrant),    32'(e.g));
        chk({e.tag, ".hmaster"},   32'(hmaster),   32'(e.m));
        chk({e.tag, ".hmastlock"}, 32'(hmastlock), 32'(e.l));
      end
    end
  end

  initial begin : stim
    hreset = 1'b1; busreq = '0; hlock = '0; htrans = IDLE; hburst = SGL;
    hready = 1'b1; hresp = 2'b00;

    // 1: reset, no requests -> default master, stable
    cyc(1, 4'b0000, 4'b0000, IDLE, SGL, 1, 0, 4'b0001, 0, 0, "t1_rst");
    for (int i = 0; i < 10; i++)
      cyc(0, 4'b0000, 4'b0000, IDLE, SGL, 1, 0, 4'b0001, 0, 0, "t1_idle");

    // 2: all request, SINGLE transfers -> rotation, hmaster one cycle behind
    for (int i = 0; i < 6; i++)
      cyc(0, 4'b1111, 4'b0000, NS, SGL, 1, 0, t2_g[i], t2_m[i], 0, "t2_rr");

    // 3: M1 INCR4 with two wait states on beat 2, M2 requesting throughout
    cyc(0, 4'b0010, 4'b0000, IDLE, SGL,   1, 0, 4'b0010, 2, 0, "t3_gnt");
    cyc(0, 4'b0010, 4'b0000, IDLE, SGL,   1, 0, 4'b0010, 1, 0, "t3_own");
    cyc(0, 4'b0110, 4'b0000, NS,   INCR4, 1, 0, 4'b0010, 1, 0, "t3_b1");
    cyc(0, 4'b0110, 4'b0000, SEQ,  INCR4, 0, 0, 4'b0010, 1, 0, "t3_w1");
    cyc(0, 4'b0110, 4'b0000, SEQ,  INCR4, 0, 0, 4'b0010, 1, 0, "t3_w2");
    cyc(0, 4'b0110, 4'b0000, SEQ,  INCR4, 1, 0, 4'b0010, 1, 0, "t3_b2");
    cyc(0, 4'b0110, 4'b0000, SEQ,  INCR4, 1, 0, 4'b0010, 1, 0, "t3_b3");
    cyc(0, 4'b0110, 4'b0000, SEQ,  INCR4, 1, 0, 4'b0100, 1, 0, "t3_b4");
    cyc(0, 4'b0100, 4'b0000, IDLE, SGL,   1, 0, 4'b0100, 2, 0, "t3_post");

    // 4: M3 locked sequence, others requesting; burst inside lock not counted
    cyc(0, 4'b1111, 4'b1000, NS,   SGL,   1, 0, 4'b1000, 2, 0, "t4_lgnt");
    cyc(0, 4'b1111, 4'b1000, NS,   SGL,   1, 0, 4'b1000, 3, 1, "t4_l1");
    cyc(0, 4'b1111, 4'b1000, NS,   INCR4, 1, 0, 4'b1000, 3, 1, "t4_l2");
    cyc(0, 4'b1111, 4'b1000, SEQ,  INCR4, 1, 0, 4'b1000, 3, 1, "t4_l3");
    cyc(0, 4'b1111, 4'b1000, SEQ,  INCR4, 1, 0, 4'b1000, 3, 1, "t4_l4");
    cyc(0, 4'b1111, 4'b1000, SEQ,  INCR4, 1, 0, 4'b1000, 3, 1, "t4_l5");
    cyc(0, 4'b1111, 4'b0000, SEQ,  INCR4, 1, 0, 4'b1000, 3, 0, "t4_unlk");
    cyc(0, 4'b1111, 4'b0000, IDLE, SGL,   1, 0, 4'b0001, 3, 0, "t4_move");
    cyc(0, 4'b0001, 4'b0000, IDLE, SGL,   1, 0, 4'b0001, 0, 0, "t4_post");

    // 5: M2 INCR8, ERROR at beat 3 -> abort, grant to M0 on the hready edge
    cyc(0, 4'b0100, 4'b0000, IDLE, SGL,   1, 0, 4'b0100, 0, 0, "t5_gnt");
    cyc(0, 4'b0100, 4'b0000, IDLE, SGL,   1, 0, 4'b0100, 2, 0, "t5_own");
    cyc(0, 4'b0101, 4'b0000, NS,   INCR8, 1, 0, 4'b0100, 2, 0, "t5_b1");
    cyc(0, 4'b0101, 4'b0000, SEQ,  INCR8, 1, 0, 4'b0100, 2, 0, "t5_b2");
    cyc(0, 4'b0101, 4'b0000, SEQ,  INCR8, 0, 1, 4'b0100, 2, 0, "t5_err1");
    cyc(0, 4'b0101, 4'b0000, SEQ,  INCR8, 1, 1, 4'b0001, 2, 0, "t5_err2");
    cyc(0, 4'b0001, 4'b0000, IDLE, SGL,   1, 0, 4'b0001, 0, 0, "t5_post");

    // 6: reset in the middle of an M1 INCR16; burst must not resume
    cyc(0, 4'b0010, 4'b0000, IDLE, SGL,    1, 0, 4'b0010, 0, 0, "t6_gnt");
    cyc(0, 4'b0010, 4'b0000, IDLE, SGL,    1, 0, 4'b0010, 1, 0, "t6_own");
    cyc(0, 4'b0011, 4'b0000, NS,   INCR16, 1, 0, 4'b0010, 1, 0, "t6_b1");
    cyc(0, 4'b0011, 4'b0000, SEQ,  INCR16, 1, 0, 4'b0010, 1, 0, "t6_b2");
    cyc(0, 4'b0011, 4'b0000, SEQ,  INCR16, 1, 0, 4'b0010, 1, 0, "t6_b3");
    cyc(0, 4'b0011, 4'b0000, SEQ,  INCR16, 1, 0, 4'b0010, 1, 0, "t6_b4");
    cyc(1, 4'b0011, 4'b0000, SEQ,  INCR16, 1, 0, 4'b0001, 0, 0, "t6_rst");
    cyc(0, 4'b0011, 4'b0000, SEQ,  INCR16, 1, 0, 4'b0010, 0, 0, "t6_arb1");
    cyc(0, 4'b0011, 4'b0000, SEQ,  INCR16, 1, 0, 4'b0001, 1, 0, "t6_arb2");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge hclk);
    #2;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
